// File: rtl/audio_clk_gen.sv
// ---------------------------------------------------------------------------
// audio_clk_gen
//   Derives an audio bit clock (bclk) and LR clock / frame sync (lrclk) from
//   the PLL output clock. The block waits for a synchronised, filtered PLL
//   lock before running, and drops back to idle as soon as lock is lost.
//   BCLK divider and I2S/TDM mode are sampled only at frame boundaries, so
//   configuration changes never produce a truncated clock pulse.
//
// Ports
//   clkin       in   single clock, all logic on rising edge
//   reset       in   asynchronous active-high reset
//   pll_lock    in   PLL lock, asynchronous to clkin
//   div_sel     in   BCLK half-period = div_sel+1 clkin cycles
//   tdm_mode    in   0: I2S 50% LRCLK, 1: TDM one-BCLK frame sync
//   bclk        out  bit clock
//   lrclk       out  LR clock (I2S) or frame sync (TDM)
//   bclk_rise   out  one-cycle strobe, bclk just became 1
//   bclk_fall   out  one-cycle strobe, bclk just became 0
//   frame_start out  one-cycle strobe at the first cycle of each frame
//   slot_idx    out  current slot in frame
//   bit_idx     out  current bit in slot
//   running     out  block is in RUN
//
// state | meaning
// IDLE  | no synchronised lock; everything held at 0
// FILT  | lock seen; counting down the lock qualification window
// RUN   | generating bclk / lrclk
// ---------------------------------------------------------------------------
module audio_clk_gen #(
    parameter int SLOT_W    = 32,
    parameter int N_SLOTS   = 2,
    parameter int LOCK_FILT = 1024,
    parameter int DIV_W     = 4
) (
    input  logic                       clkin,
    input  logic                       reset,
    input  logic                       pll_lock,
    input  logic [DIV_W-1:0]           div_sel,
    input  logic                       tdm_mode,
    output logic                       bclk,
    output logic                       lrclk,
    output logic                       bclk_rise,
    output logic                       bclk_fall,
    output logic                       frame_start,
    output logic [$clog2(N_SLOTS)-1:0] slot_idx,
    output logic [$clog2(SLOT_W)-1:0]  bit_idx,
    output logic                       running
);

    localparam int BIT_W  = $clog2(SLOT_W);
    localparam int SLOT_IW = $clog2(N_SLOTS);
    localparam int FILT_W = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;

    localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(SLOT_W - 1);
    localparam logic [SLOT_IW-1:0] SLOT_LAST = SLOT_IW'(N_SLOTS - 1);
    localparam logic [FILT_W-1:0]  FILT_LOAD = FILT_W'(LOCK_FILT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILT = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t             state;
    logic               lock_meta;
    logic               lock_s;
    logic [FILT_W-1:0]  filt_cnt;
    logic [DIV_W-1:0]   half_cnt;
    logic [DIV_W-1:0]   cfg_div;
    logic               cfg_tdm;
    logic [SLOT_IW-1:0] slot_nxt;

    assign slot_nxt = slot_idx + 1'b1;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            filt_cnt    <= '0;
            half_cnt    <= '0;
            cfg_div     <= '0;
            cfg_tdm     <= 1'b0;
            bclk        <= 1'b0;
            lrclk       <= 1'b0;
            bclk_rise   <= 1'b0;
            bclk_fall   <= 1'b0;
            frame_start <= 1'b0;
            slot_idx    <= '0;
            bit_idx     <= '0;
            running     <= 1'b0;
        end else begin
            bclk_rise   <= 1'b0;
            bclk_fall   <= 1'b0;
            frame_start <= 1'b0;

            // Lock loss overrides everything, including a pending RUN entry.
            if (!lock_s) begin
                state    <= IDLE;
                filt_cnt <= '0;
                half_cnt <= '0;
                cfg_div  <= '0;
                cfg_tdm  <= 1'b0;
                bclk     <= 1'b0;
                lrclk    <= 1'b0;
                slot_idx <= '0;
                bit_idx  <= '0;
                running  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= FILT;
                        filt_cnt <= FILT_LOAD;
                    end

                    FILT: begin
                        if (filt_cnt == '0) begin
                            state       <= RUN;
                            running     <= 1'b1;
                            cfg_div     <= div_sel;
                            cfg_tdm     <= tdm_mode;
                            half_cnt    <= '0;
                            bclk        <= 1'b0;
                            slot_idx    <= '0;
                            bit_idx     <= '0;
                            frame_start <= 1'b1;
                            // Slot 0 bit 0: frame sync high in TDM, left channel in I2S.
                            lrclk       <= tdm_mode;
                        end else begin
                            filt_cnt <= filt_cnt - 1'b1;
                        end
                    end

                    RUN: begin
                        if (half_cnt == cfg_div) begin
                            half_cnt <= '0;
                            bclk     <= ~bclk;
                            if (!bclk) begin
                                bclk_rise <= 1'b1;
                            end else begin
                                // Falling edge: advance bit/slot position.
                                bclk_fall <= 1'b1;
                                if (bit_idx == BIT_LAST) begin
                                    bit_idx <= '0;
                                    if (slot_idx == SLOT_LAST) begin
                                        // Frame boundary: only place config is resampled.
                                        slot_idx    <= '0;
                                        frame_start <= 1'b1;
                                        cfg_div     <= div_sel;
                                        cfg_tdm     <= tdm_mode;
                                        lrclk       <= tdm_mode;
                                    end else begin
                                        slot_idx <= slot_nxt;
                                        // Upper half of the slots is the right channel.
                                        lrclk    <= cfg_tdm ? 1'b0 : slot_nxt[SLOT_IW-1];
                                    end
                                end else begin
                                    bit_idx <= bit_idx + 1'b1;
                                    lrclk   <= cfg_tdm ? 1'b0 : slot_idx[SLOT_IW-1];
                                end
                            end
                        end else begin
                            half_cnt <= half_cnt + 1'b1;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_clk_gen.sv
// ---------------------------------------------------------------------------
// tb_audio_clk_gen
//   Two instances: dut0 (SLOT_W=32, N_SLOTS=2) and dut4 (SLOT_W=16,
//   N_SLOTS=4), both with LOCK_FILT=16 and sharing clock, reset and lock.
//   A reference model derives every output from the elapsed time within the
//   current frame and the frame's latched configuration; it is compared with
//   both instances on every falling clock edge. Directed scenarios add
//   explicit timing measurements.
// ---------------------------------------------------------------------------
module tb_audio_clk_gen;

    localparam int LF = 16;

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock = 1'b1;
    logic [3:0] div_sel0 = 4'd1;
    logic       tdm0 = 1'b0;
    logic [3:0] div_sel1 = 4'd0;
    logic       tdm1 = 1'b1;

    logic       bclk0, lrclk0, rise0, fall0, fs0, running0;
    logic [0:0] slot0;
    logic [4:0] bit0;
    logic       bclk1, lrclk1, rise1, fall1, fs1, running1;
    logic [1:0] slot1;
    logic [3:0] bit1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clkin = ~clkin;

    audio_clk_gen #(.SLOT_W(32), .N_SLOTS(2), .LOCK_FILT(LF), .DIV_W(4)) dut0 (
        .clkin(clkin), .reset(reset), .pll_lock(pll_lock),
        .div_sel(div_sel0), .tdm_mode(tdm0),
        .bclk(bclk0), .lrclk(lrclk0), .bclk_rise(rise0), .bclk_fall(fall0),
        .frame_start(fs0), .slot_idx(slot0), .bit_idx(bit0), .running(running0)
    );

    audio_clk_gen #(.SLOT_W(16), .N_SLOTS(4), .LOCK_FILT(LF), .DIV_W(4)) dut4 (
        .clkin(clkin), .reset(reset), .pll_lock(pll_lock),
        .div_sel(div_sel1), .tdm_mode(tdm1),
        .bclk(bclk1), .lrclk(lrclk1), .bclk_rise(rise1), .bclk_fall(fall1),
        .frame_start(fs1), .slot_idx(slot1), .bit_idx(bit1), .running(running1)
    );

    // Packed view: [21]running [20]bclk [19]lrclk [18]rise [17]fall
    //              [16]frame_start [15:8]slot [7:0]bit
    logic [31:0] act0, act1;
    assign act0 = {10'b0, running0, bclk0, lrclk0, rise0, fall0, fs0, 7'b0, slot0, 3'b0, bit0};
    assign act1 = {10'b0, running1, bclk1, lrclk1, rise1, fall1, fs1, 6'b0, slot1, 4'b0, bit1};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] actv(input int i);
        return (i == 0) ? act0 : act1;
    endfunction

    // ---------------- reference model ----------------
    int   run_len;
    logic [2:0] qh;
    logic exp_run;
    int   m_t[2];
    int   m_d[2];
    logic m_tdm[2];
    logic m_first[2];
    int   sw_v[2] = '{32, 16};
    int   ns_v[2] = '{2, 4};

    function automatic int frame_len(input int i);
        return 2 * (m_d[i] + 1) * sw_v[i] * ns_v[i];
    endfunction

    function automatic logic [31:0] exp_vec(input int i);
        int half, per, ph, bn, sl, bt;
        logic lr, bc, ri, fa, fs;
        if (!exp_run) return 32'h0;
        half = m_d[i] + 1;
        per  = 2 * half;
        ph   = m_t[i] % per;
        bn   = m_t[i] / per;
        sl   = bn / sw_v[i];
        bt   = bn % sw_v[i];
        bc   = (ph >= half);
        ri   = (ph == half);
        fa   = (ph == 0) && !(m_first[i] && m_t[i] == 0);
        fs   = (m_t[i] == 0);
        lr   = m_tdm[i] ? (bn == 0) : (sl >= ns_v[i] / 2);
        return {10'b0, 1'b1, bc, lr, ri, fa, fs, 8'(sl), 8'(bt)};
    endfunction

    initial begin : model
        logic prev;
        run_len = 0;
        qh      = '0;
        exp_run = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_t[i] = 0; m_d[i] = 0; m_tdm[i] = 1'b0; m_first[i] = 1'b0;
        end
        forever begin
            @(posedge clkin or posedge reset);
            if (reset) begin
                run_len = 0;
                qh      = '0;
                exp_run = 1'b0;
            end else begin
                // Running is due two synchroniser cycles after the lock
                // history shows LOCK_FILT+1 consecutive high samples.
                run_len = pll_lock ? run_len + 1 : 0;
                qh      = {qh[1:0], (run_len >= LF + 1)};
                prev    = exp_run;
                exp_run = qh[2];
                for (int i = 0; i < 2; i++) begin
                    if (exp_run && !prev) begin
                        m_t[i]     = 0;
                        m_d[i]     = (i == 0) ? int'(div_sel0) : int'(div_sel1);
                        m_tdm[i]   = (i == 0) ? tdm0 : tdm1;
                        m_first[i] = 1'b1;
                    end else if (exp_run) begin
                        m_t[i]++;
                        if (m_t[i] == frame_len(i)) begin
                            m_t[i]     = 0;
                            m_d[i]     = (i == 0) ? int'(div_sel0) : int'(div_sel1);
                            m_tdm[i]   = (i == 0) ? tdm0 : tdm1;
                            m_first[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clkin);
            chk("model_dut0", act0, exp_vec(0));
            chk("model_dut4", act1, exp_vec(1));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_running(output int n);
        bit done;
        done = 0;
        n = -1;
        for (int k = 1; k <= 200 && !done; k++) begin
            @(posedge clkin); #1;
            if (running0) begin n = k; done = 1; end
        end
    endtask

    task automatic wait_drop(output int n);
        bit done;
        done = 0;
        n = -1;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(posedge clkin); #1;
            if (!running0) begin n = k; done = 1; end
        end
    endtask

    task automatic wait_fs(input int i, output bit ok);
        ok = 0;
        for (int k = 0; k < 5000 && !ok; k++) begin
            @(posedge clkin); #1;
            if (actv(i)[16]) ok = 1;
        end
    endtask

    task automatic frame_stats(input int i, output int len, output int hi, output int maxbit);
        bit ok, done;
        logic [31:0] v;
        len = -1; hi = 0; maxbit = 0; done = 0;
        wait_fs(i, ok);
        if (ok) begin
            v = actv(i);
            hi = int'(v[19]);
            maxbit = int'(v[7:0]);
            for (int k = 1; k <= 5000 && !done; k++) begin
                @(posedge clkin); #1;
                v = actv(i);
                if (v[16]) begin
                    len = k; done = 1;
                end else begin
                    hi += int'(v[19]);
                    if (int'(v[7:0]) > maxbit) maxbit = int'(v[7:0]);
                end
            end
        end
    endtask

    task automatic measure_period(input int i, output int p);
        bit seen, done;
        int cnt;
        seen = 0; done = 0; cnt = 0; p = -1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge clkin); #1;
            if (seen) cnt++;
            if (actv(i)[18]) begin
                if (seen) begin p = cnt; done = 1; end
                seen = 1; cnt = 0;
            end
        end
    endtask

    task automatic pulse_min(input int i, input int cycles, output int mn);
        logic prev;
        int run;
        bit toggled;
        prev = actv(i)[20]; run = 0; toggled = 0; mn = 1000;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clkin); #1;
            if (actv(i)[20] != prev) begin
                if (toggled && run < mn) mn = run;
                toggled = 1;
                run = 1;
                prev = actv(i)[20];
            end else begin
                run++;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int n, len, hi, mb, p, mn;
        bit ok;

        repeat (3) @(negedge clkin);
        chk("reset_outs0", act0, 32'h0);
        chk("reset_outs4", act1, 32'h0);

        // Lock already high at reset release.
        reset = 1'b0;
        wait_running(n);
        chk("lock_hold", 32'(n), 32'd19);
        chk("entry_fs", {31'b0, fs0}, 32'd1);

        // I2S, div 1 on dut0; TDM, div 0 on dut4.
        frame_stats(0, len, hi, mb);
        chk("i2s_frame_len", 32'(len), 32'd256);
        chk("i2s_lr_high", 32'(hi), 32'd128);
        chk("i2s_max_bit", 32'(mb), 32'd31);
        measure_period(0, p);
        chk("i2s_period", 32'(p), 32'd4);

        frame_stats(1, len, hi, mb);
        chk("tdm_frame_len", 32'(len), 32'd128);
        chk("tdm_lr_high", 32'(hi), 32'd2);
        chk("tdm_max_bit", 32'(mb), 32'd15);

        // Divider change mid-frame takes effect only at the next frame.
        wait_fs(0, ok);
        chk("fs_seen", {31'b0, ok}, 32'd1);
        repeat (50) @(negedge clkin);
        div_sel0 = 4'd3;
        measure_period(0, p);
        chk("div_old_period", 32'(p), 32'd4);
        pulse_min(0, 300, mn);
        chk("min_pulse", 32'(mn), 32'd2);
        measure_period(0, p);
        chk("div_new_period", 32'(p), 32'd8);

        // Lock loss mid-frame, then relock.
        repeat (37) @(negedge clkin);
        pll_lock = 1'b0;
        wait_drop(n);
        chk("drop_latency", 32'(n), 32'd3);
        chk("drop_outs0", act0, 32'h0);
        chk("drop_outs4", act1, 32'h0);
        repeat (10) @(negedge clkin);
        div_sel0 = 4'd1;
        pll_lock = 1'b1;
        wait_running(n);
        chk("relock_time", 32'(n), 32'd19);
        chk("relock_fs", {31'b0, fs0}, 32'd1);
        chk("relock_slot", {31'b0, slot0}, 32'd0);

        // Asynchronous reset between clock edges.
        repeat (123) @(negedge clkin);
        @(posedge clkin); #3;
        reset = 1'b1;
        #1;
        chk("async_rst0", act0, 32'h0);
        chk("async_rst4", act1, 32'h0);
        @(negedge clkin);
        reset = 1'b0;
        wait_running(n);
        chk("rst_relock_time", 32'(n), 32'd19);

        // Randomised config changes and lock glitches against the model.
        for (int k = 0; k < 4000; k++) begin
            @(negedge clkin);
            if ($urandom_range(0, 40) == 0) div_sel0 = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 40) == 0) div_sel1 = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 60) == 0) tdm0 = ~tdm0;
            if ($urandom_range(0, 60) == 0) tdm1 = ~tdm1;
            if ($urandom_range(0, 700) == 0) begin
                pll_lock = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clkin);
                pll_lock = 1'b1;
            end
        end

        repeat (2) @(negedge clkin);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/audio_clk_gen.md
AUDIO_CLK_GEN -- requirements
Module: audio_clk_gen

Interface
REQ-001 SHALL have parameter SLOT_W, default 32, meaning bits per slot (power of 2, >=8).
REQ-002 SHALL have parameter N_SLOTS, default 2, meaning slots per frame (power of 2, 2..16).
REQ-003 SHALL have parameter LOCK_FILT, default 1024, meaning consecutive synchronised-lock cycles required before running.
REQ-004 SHALL have parameter DIV_W, default 4, meaning width of div_sel.
REQ-005 SHALL have port clkin, input, 1, meaning the single clock (PLL clkout0 / MCLK); all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-007 SHALL have port pll_lock, input, 1, meaning PLL lock, asynchronous to clkin.
REQ-008 SHALL have port div_sel, input, DIV_W, meaning BCLK half-period = div_sel+1 clkin cycles.
REQ-009 SHALL have port tdm_mode, input, 1, meaning 0 = I2S 50% LRCLK, 1 = TDM one-BCLK frame sync.
REQ-010 SHALL have ports bclk and lrclk, output, 1 each, meaning bit clock and LR clock / frame sync.
REQ-011 SHALL have ports bclk_rise, bclk_fall and frame_start, output, 1 each, meaning one-cycle strobes.
REQ-012 SHALL have port slot_idx, output, clog2(N_SLOTS), meaning current slot.
REQ-013 SHALL have port bit_idx, output, clog2(SLOT_W), meaning current bit within slot.
REQ-014 SHALL have port running, output, 1, meaning the block is in RUN.

Function
REQ-015 SHALL pass pll_lock through a 2-flop synchroniser (lock_s) before any use.
REQ-016 SHALL implement states IDLE, FILT, RUN.
REQ-017 SHALL go IDLE->FILT when lock_s=1.
REQ-018 SHALL, in FILT, count consecutive lock_s=1 cycles and enter RUN on the cycle after the count reaches LOCK_FILT-1.
REQ-019 SHALL go from any state to IDLE on the next edge when lock_s=0, clearing all counters; lock loss takes priority over every other event.
REQ-020 SHALL, outside RUN, drive all outputs and indices to 0.
REQ-021 SHALL, on entry to RUN: latch div_sel/tdm_mode into cfg registers; set bclk=0, slot_idx=0, bit_idx=0; pulse frame_start in the first RUN cycle.
REQ-022 SHALL use a half-period counter running 0..cfg_div, toggling bclk when it wraps, so bclk period = 2*(cfg_div+1) clkin cycles; cfg_div=0 gives clkin/2.
REQ-023 SHALL assert bclk_rise / bclk_fall in the same cycle the registered bclk becomes 1 / 0.
REQ-024 SHALL, on each bclk falling edge after the first, increment bit_idx, wrapping at SLOT_W-1 and then incrementing slot_idx.
REQ-025 SHALL, when slot_idx wraps at N_SLOTS-1, pulse frame_start and re-latch div_sel/tdm_mode into cfg in that same cycle; the new config is effective from the next half-period count.
REQ-026 SHALL ignore div_sel/tdm_mode changes at all other times (no mid-frame glitch).
REQ-027 SHALL, with cfg_tdm=0, drive lrclk=0 for slots 0..N_SLOTS/2-1 and 1 otherwise, changing only on bclk_fall cycles.
REQ-028 SHALL, with cfg_tdm=1, drive lrclk=1 exactly while slot_idx=0 and bit_idx=0, i.e. one full BCLK period per frame.
REQ-029 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-030 SHALL, while reset=1, immediately force state IDLE, all counters and synchronisers to 0, and all outputs to 0, independent of clkin.
REQ-031 SHALL, after reset release, require a full LOCK_FILT qualification before running=1, even if pll_lock is already high.

Verification (SLOT_W=32, N_SLOTS=2, LOCK_FILT=16 unless stated)
REQ-032 Lock hold: reset release with pll_lock=1 -> running rises exactly 2+16+1 cycles later (±1 per REQ-018 boundary, checked exactly against the RTL), and all outputs are 0 before that.
REQ-033 div_sel=1 -> bclk period 4 cycles; frame_start every 256 cycles; lrclk low 128 / high 128; bit_idx 0..31 per slot.
REQ-034 div_sel changed 1->3 mid-frame -> period stays 4 until the next frame_start, then 8; no bclk pulse shorter than 2 cycles.
REQ-035 N_SLOTS=4, SLOT_W=16, tdm_mode=1, div_sel=0 -> lrclk high exactly 2 cycles per frame, with frame_start every 128 cycles.
REQ-036 pll_lock dropped mid-frame -> within 3 cycles running=0 and all outputs 0; on relock a full filter period is required, then frame_start fires with slot_idx=0.
REQ-037 reset asserted mid-frame between clkin edges -> outputs 0 immediately; after release the same behaviour as REQ-032.
